// File: rtl/riscv_pkg.sv
// Shared RV32 core types: M-extension operation codes and multiply/divide constants.
package riscv_pkg;

    typedef enum logic [3:0] {
        MULDIV_NOP    = 4'd0,
        MULDIV_MUL    = 4'd1,
        MULDIV_MULH   = 4'd2,
        MULDIV_MULHSU = 4'd3,
        MULDIV_MULHU  = 4'd4,
        MULDIV_DIV    = 4'd5,
        MULDIV_DIVU   = 4'd6,
        MULDIV_REM    = 4'd7,
        MULDIV_REMU   = 4'd8
    } muldiv_oper_t;

    typedef enum logic [1:0] {
        MULDIV_IDLE = 2'd0,
        MULDIV_CALC = 2'd1,
        MULDIV_DONE = 2'd2
    } muldiv_state_t;

    localparam logic [31:0] MULDIV_DIV_ZERO_Q = 32'hFFFF_FFFF;
    localparam int          MULDIV_CYCLES     = 32;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: one shared 33-bit adder sequenced over 32 CALC cycles.
module muldiv_unit
    import riscv_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  muldiv_oper_t op_i,
    input  logic [31:0]  operand1_i,
    input  logic [31:0]  operand2_i,
    input  logic         flush_i,
    output logic         stall_o,
    output logic         done_o,
    output logic [31:0]  result_o
);

    function automatic logic is_div(input muldiv_oper_t op);
        return (op == MULDIV_DIV) || (op == MULDIV_DIVU) ||
               (op == MULDIV_REM) || (op == MULDIV_REMU);
    endfunction

    function automatic logic is_rem(input muldiv_oper_t op);
        return (op == MULDIV_REM) || (op == MULDIV_REMU);
    endfunction

    function automatic logic signed_op1(input muldiv_oper_t op);
        return (op == MULDIV_DIV) || (op == MULDIV_REM) ||
               (op == MULDIV_MULH) || (op == MULDIV_MULHSU);
    endfunction

    function automatic logic signed_op2(input muldiv_oper_t op);
        return (op == MULDIV_DIV) || (op == MULDIV_REM) || (op == MULDIV_MULH);
    endfunction

    // hi/lo hold the product for multiplies, remainder/quotient for divides.
    function automatic logic [31:0] select_result(input muldiv_oper_t op, input logic neg,
                                                  input logic [31:0] hi, input logic [31:0] lo);
        logic [63:0] prod;
        prod = neg ? (~{hi, lo} + 64'd1) : {hi, lo};
        case (op)
            MULDIV_MUL:                               return prod[31:0];
            MULDIV_MULH, MULDIV_MULHSU, MULDIV_MULHU: return prod[63:32];
            MULDIV_DIV, MULDIV_DIVU:                  return neg ? (~lo + 32'd1) : lo;
            MULDIV_REM, MULDIV_REMU:                  return neg ? (~hi + 32'd1) : hi;
            default:                                  return 32'd0;
        endcase
    endfunction

    muldiv_state_t state_q, state_d;
    logic [5:0]    cnt_q, cnt_d;
    muldiv_oper_t  op_q, op_d;
    logic          neg_q, neg_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    logic [31:0]   b_q, b_d;
    logic          done_q, done_d;
    logic [31:0]   result_q, result_d;

    logic          sign1, sign2;
    logic [31:0]   mag1, mag2;
    logic          div_q_op;
    logic [32:0]   add_a, add_b, add_sum;

    assign sign1 = signed_op1(op_i) & operand1_i[31];
    assign sign2 = signed_op2(op_i) & operand2_i[31];
    assign mag1  = sign1 ? (~operand1_i + 32'd1) : operand1_i;
    assign mag2  = sign2 ? (~operand2_i + 32'd1) : operand2_i;

    // Divide trial-subtracts via inverted addend plus carry-in; multiply adds when lo[0] is set.
    assign div_q_op = is_div(op_q);
    assign add_a    = div_q_op ? {hi_q, lo_q[31]} : {1'b0, hi_q};
    assign add_b    = div_q_op ? ~{1'b0, b_q} : (lo_q[0] ? {1'b0, b_q} : 33'd0);
    assign add_sum  = add_a + add_b + {32'd0, div_q_op};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        b_d      = b_q;
        done_d   = 1'b0;
        result_d = result_q;

        case (state_q)
            MULDIV_IDLE: begin
                if (start_i) begin
                    op_d    = op_i;
                    hi_d    = 32'd0;
                    lo_d    = mag1;
                    b_d     = mag2;
                    neg_d   = is_rem(op_i) ? sign1 : (sign1 ^ sign2);
                    cnt_d   = 6'(MULDIV_CYCLES);
                    state_d = MULDIV_CALC;
                    if (is_div(op_i) && (operand2_i == 32'd0)) begin
                        cnt_d    = 6'd0;
                        state_d  = MULDIV_DONE;
                        done_d   = 1'b1;
                        result_d = is_rem(op_i) ? operand1_i : MULDIV_DIV_ZERO_Q;
                    end else if (((op_i == MULDIV_DIV) || (op_i == MULDIV_REM)) &&
                                 (operand1_i == 32'h8000_0000) &&
                                 (operand2_i == 32'hFFFF_FFFF)) begin
                        cnt_d    = 6'd0;
                        state_d  = MULDIV_DONE;
                        done_d   = 1'b1;
                        result_d = is_rem(op_i) ? 32'd0 : 32'h8000_0000;
                    end
                end
            end
            MULDIV_CALC: begin
                cnt_d = cnt_q - 6'd1;
                if (div_q_op) begin
                    if (!add_sum[32]) begin
                        hi_d = add_sum[31:0];
                        lo_d = {lo_q[30:0], 1'b1};
                    end else begin
                        hi_d = {hi_q[30:0], lo_q[31]};
                        lo_d = {lo_q[30:0], 1'b0};
                    end
                end else begin
                    hi_d = add_sum[32:1];
                    lo_d = {add_sum[0], lo_q[31:1]};
                end
                if (cnt_q == 6'd1) begin
                    state_d  = MULDIV_DONE;
                    done_d   = 1'b1;
                    result_d = select_result(op_q, neg_q, hi_d, lo_d);
                end
            end
            MULDIV_DONE: begin
                state_d = MULDIV_IDLE;
            end
            default: begin
                state_d = MULDIV_IDLE;
            end
        endcase

        if (flush_i) begin
            state_d  = MULDIV_IDLE;
            cnt_d    = 6'd0;
            done_d   = 1'b0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= MULDIV_IDLE;
            cnt_q    <= 6'd0;
            done_q   <= 1'b0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
        op_q  <= op_d;
        neg_q <= neg_d;
        hi_q  <= hi_d;
        lo_q  <= lo_d;
        b_q   <= b_d;
    end

    assign stall_o  = ((state_q == MULDIV_IDLE) && start_i && !flush_i) ||
                      (state_q == MULDIV_CALC);
    assign done_o   = done_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed RV32M cases plus random operations against an arithmetic model.
module tb_muldiv_unit;
    import riscv_pkg::*;

    logic         clk;
    logic         rst;
    logic         start;
    muldiv_oper_t op;
    logic [31:0]  opa;
    logic [31:0]  opb;
    logic         flush;
    logic         stall;
    logic         done;
    logic [31:0]  result;

    int n_checks = 0;
    int n_errors = 0;

    muldiv_unit dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .op_i       (op),
        .operand1_i (opa),
        .operand2_i (opb),
        .flush_i    (flush),
        .stall_o    (stall),
        .done_o     (done),
        .result_o   (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // RV32M semantics from plain 64-bit integer arithmetic.
    function automatic logic [31:0] model(input muldiv_oper_t o, input logic [31:0] a,
                                          input logic [31:0] b);
        longint p;
        int     sa, sb, q;
        sa = a;
        sb = b;
        case (o)
            MULDIV_MUL:    begin p = longint'(a) * longint'(b);                   return p[31:0];  end
            MULDIV_MULH:   begin p = longint'($signed(a)) * longint'($signed(b)); return p[63:32]; end
            MULDIV_MULHSU: begin p = longint'($signed(a)) * longint'({32'd0, b}); return p[63:32]; end
            MULDIV_MULHU:  begin p = longint'({32'd0, a}) * longint'({32'd0, b}); return p[63:32]; end
            MULDIV_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                q = sa / sb;
                return q;
            end
            MULDIV_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            MULDIV_REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                q = sa % sb;
                return q;
            end
            MULDIV_REMU:   return (b == 0) ? a : a % b;
            default:       return 32'd0;
        endcase
    endfunction

    function automatic bit is_fast(input muldiv_oper_t o, input logic [31:0] a, input logic [31:0] b);
        bit d;
        d = (o == MULDIV_DIV) || (o == MULDIV_DIVU) || (o == MULDIV_REM) || (o == MULDIV_REMU);
        if (d && b == 0) return 1'b1;
        return ((o == MULDIV_DIV) || (o == MULDIV_REM)) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    endfunction

    // Start holds high while the pipeline is stalled and drops the cycle after done.
    task automatic run_op(input string tag, input muldiv_oper_t o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int  lat, low_cyc, done_cyc, done_cnt;
        bit  seen;
        logic [31:0] res_at_done, res_after;
        lat = is_fast(o, a, b) ? 1 : 33;
        low_cyc = -1; done_cyc = -1; done_cnt = 0; seen = 0;
        res_at_done = 32'd0; res_after = 32'd0;
        @(posedge clk); #1;
        start = 1'b1; op = o; opa = a; opb = b;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!stall && low_cyc < 0) low_cyc = c;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    res_at_done = result;
                end
            end
            if (done_cyc >= 0 && c == done_cyc + 1) res_after = result;
            @(posedge clk); #1;
            if (done && !seen) begin
                start = 1'b0;
                seen = 1'b1;
            end
        end
        start = 1'b0;
        check({tag, "_stall_low_cyc"}, 32'(low_cyc), 32'(lat));
        check({tag, "_done_cyc"}, 32'(done_cyc), 32'(lat));
        check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
        check({tag, "_result"}, res_at_done, exp);
        check({tag, "_hold"}, res_after, exp);
    endtask

    initial begin
        muldiv_oper_t ro;
        logic [31:0]  ra, rb;
        logic [31:0]  prev;
        int           done_cnt;

        rst = 1'b1; start = 1'b0; flush = 1'b0; op = MULDIV_NOP; opa = 32'd0; opb = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_stall", {31'd0, stall}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_op("mul",      MULDIV_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB);
        run_op("mulhu",    MULDIV_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("mulh",     MULDIV_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000);
        run_op("mulhsu",   MULDIV_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("div",      MULDIV_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD);
        run_op("rem",      MULDIV_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF);
        run_op("divu",     MULDIV_DIVU,   32'd100,        32'd7,         32'd14);
        run_op("remu",     MULDIV_REMU,   32'd100,        32'd7,         32'd2);
        run_op("divu_z",   MULDIV_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF);
        run_op("remu_z",   MULDIV_REMU,   32'd5,          32'd0,         32'd5);
        run_op("div_ovf",  MULDIV_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000);
        run_op("rem_ovf",  MULDIV_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0);

        // Flush a multiply at cycle 10; EX is cleared so start drops with it.
        prev = result;
        done_cnt = 0;
        @(posedge clk); #1;
        start = 1'b1; op = MULDIV_MUL; opa = 32'd1234; opb = 32'd5678;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done) done_cnt++;
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(negedge clk);
        check("flush_stall_c10", {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        flush = 1'b0; start = 1'b0;
        @(negedge clk);
        check("flush_stall_c11", {31'd0, stall}, 32'd0);
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("flush_no_done", 32'(done_cnt), 32'd0);
        check("flush_result_kept", result, prev);
        run_op("divu_after_flush", MULDIV_DIVU, 32'd9, 32'd3, 32'd3);

        // Reset at cycle 20 of a signed divide.
        @(posedge clk); #1;
        start = 1'b1; op = MULDIV_DIV; opa = 32'd1000; opb = 32'hFFFF_FFF9;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_stall", {31'd0, stall}, 32'd0);
        check("rst_mid_done", {31'd0, done}, 32'd0);
        check("rst_mid_result", result, 32'd0);
        done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("rst_mid_no_done", 32'(done_cnt), 32'd0);

        for (int i = 0; i < 40; i++) begin
            ro = muldiv_oper_t'(4'($urandom_range(1, 8)));
            case ($urandom_range(0, 7))
                0:       ra = 32'd0;
                1:       ra = 32'h8000_0000;
                2:       ra = 32'hFFFF_FFFF;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'd1;
                3:       rb = $urandom_range(1, 255);
                default: rb = $urandom;
            endcase
            run_op($sformatf("rnd%0d_%s", i, ro.name()), ro, ra, rb, model(ro, ra, rb));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
